vedic_mul16_seq: RTL

Iterative 16x16 unsigned Vedic multiplier that produces a 32-bit product in four accumulate cycles. Each cycle forms one 8x8 partial product (LL, LH, HL, HH) with a combinational Vedic 8x8 core. It adds that partial product into a 32-bit accumulator through the team's existing 16-bit Kogge-Stone adder, `KoggeStoneAdder_16`. The block sits directly upstream of result consumers and is the sequential, area-reduced alternative to a fully combinational 16x16 Vedic tree.

---
 rtl/vedic_pkg.sv | 44 ++++
 rtl/KoggeStoneAdder_16.sv | 50 +++++
 rtl/vedic_mul8.sv | 28 ++
 rtl/vedic_mul16_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vedic_pkg
// Purpose  : Shared states, widths, offsets and the 4x4 Vedic cell.
// Revision : 1.0  initial release
// ============================================================================
package vedic_pkg;

    localparam int W8  = 8;
    localparam int W16 = 16;
    localparam int W32 = 32;

    localparam int OFF_LL  = 0;
    localparam int OFF_MID = 8;
    localparam int OFF_HH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LL   = 3'd1,
        ST_LH   = 3'd2,
        ST_HL   = 3'd3,
        ST_HH   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Urdhva-Tiryakbhyam 4x4: sum each vertical/crosswise column, then weight it.
    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] r;
        logic [7:0] col;
        r = 8'd0;
        for (int k = 0; k < 7; k++) begin
            col = 8'd0;
            for (int i = 0; i < 4; i++) begin
                if ((k - i) >= 0 && (k - i) < 4) begin
                    col = col + 8'(x[i] & y[k-i]);
                end
            end
            r = r + (col << k);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/KoggeStoneAdder_16.sv
`default_nettype none
// ============================================================================
// Module   : KoggeStoneAdder_16
// Purpose  : 16-bit parallel-prefix (Kogge-Stone) adder with carry in/out.
// Revision : 1.0  initial release
// ============================================================================
module KoggeStoneAdder_16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_g3, w_p3, w_g4, w_p4;
    logic [16:0] w_c;

    assign w_g0 = a_i & b_i;
    assign w_p0 = a_i ^ b_i;

    // Each level doubles the prefix span: 1, 2, 4, 8.
    always_comb begin
        w_g1 = w_g0; w_p1 = w_p0;
        for (int i = 1; i < 16; i++) begin
            w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
            w_p1[i] = w_p0[i] & w_p0[i-1];
        end
        w_g2 = w_g1; w_p2 = w_p1;
        for (int i = 2; i < 16; i++) begin
            w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
            w_p2[i] = w_p1[i] & w_p1[i-2];
        end
        w_g3 = w_g2; w_p3 = w_p2;
        for (int i = 4; i < 16; i++) begin
            w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[i-4]);
            w_p3[i] = w_p2[i] & w_p2[i-4];
        end
        w_g4 = w_g3; w_p4 = w_p3;
        for (int i = 8; i < 16; i++) begin
            w_g4[i] = w_g3[i] | (w_p3[i] & w_g3[i-8]);
            w_p4[i] = w_p3[i] & w_p3[i-8];
        end
    end

    assign w_c    = {w_g4 | (w_p4 & {16{cin_i}}), cin_i};
    assign sum_o  = w_p0 ^ w_c[15:0];
    assign cout_o = w_c[16];

endmodule
`default_nettype wire

// File: rtl/vedic_mul8.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mul8
// Purpose  : Combinational 8x8 -> 16 unsigned Vedic multiplier from 4x4 cells.
// Revision : 1.0  initial release
// ============================================================================
module vedic_mul8
    import vedic_pkg::*;
(
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    logic [7:0] w_ll;
    logic [7:0] w_lh;
    logic [7:0] w_hl;
    logic [7:0] w_hh;

    assign w_ll = vedic4(a_i[3:0], b_i[3:0]);
    assign w_lh = vedic4(a_i[3:0], b_i[7:4]);
    assign w_hl = vedic4(a_i[7:4], b_i[3:0]);
    assign w_hh = vedic4(a_i[7:4], b_i[7:4]);

    assign p_o = {w_hh, w_ll} + ({8'd0, w_lh} << 4) + ({8'd0, w_hl} << 4);

endmodule
`default_nettype wire

// File: rtl/vedic_mul16_seq.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mul16_seq
// Purpose  : Iterative 16x16 -> 32 Vedic multiplier, four accumulate cycles.
// Revision : 1.0  initial release
// ============================================================================
module vedic_mul16_seq
    import vedic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    state_e      state_q, state_d;
    logic [15:0] ra_q, ra_d, rb_q, rb_d;
    logic [31:0] acc_q, acc_d;

    logic [7:0]  w_op_a, w_op_b;
    logic [15:0] w_pp, w_win, w_sum;
    logic        w_cout;

    assign w_op_a = (state_q == ST_LL || state_q == ST_LH) ? ra_q[7:0] : ra_q[15:8];
    assign w_op_b = (state_q == ST_LL || state_q == ST_HL) ? rb_q[7:0] : rb_q[15:8];

    vedic_mul8 u_mul8 (
        .a_i (w_op_a),
        .b_i (w_op_b),
        .p_o (w_pp)
    );

    always_comb begin
        case (state_q)
            ST_LL:        w_win = acc_q[OFF_LL  +: W16];
            ST_LH, ST_HL: w_win = acc_q[OFF_MID +: W16];
            ST_HH:        w_win = acc_q[OFF_HH  +: W16];
            default:      w_win = 16'd0;
        endcase
    end

    KoggeStoneAdder_16 u_add (
        .a_i    (w_win),
        .b_i    (w_pp),
        .cin_i  (1'b0),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    acc_d   = 32'd0;
                    state_d = ST_LL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LL: begin
                acc_d   = {acc_q[31:16] + {15'd0, w_cout}, w_sum};
                state_d = ST_LH;
            end
            ST_LH, ST_HL: begin
                // Carry out of the middle window ripples into the top byte.
                acc_d   = {acc_q[31:24] + {7'd0, w_cout}, w_sum, acc_q[7:0]};
                state_d = (state_q == ST_LH) ? ST_HL : ST_HH;
            end
            ST_HH: begin
                acc_d   = {w_sum, acc_q[15:0]};
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= 16'd0;
            rb_q    <= 16'd0;
            acc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            if (state_q == ST_HH) begin
                assert (!w_cout) else $error("vedic_mul16_seq: carry out of HH step");
            end
        end
    end

    assign busy    = (state_q == ST_LL) || (state_q == ST_LH) ||
                     (state_q == ST_HL) || (state_q == ST_HH);
    assign done    = (state_q == ST_DONE);
    assign product = acc_q;

endmodule
`default_nettype wire
